// File: rtl/rcv_shift.sv
// SPI receive shifter: samples sin MSB-first on posedge, assembles WIDTH-bit
// words and queues them in a small FIFO drained with a valid/ready handshake.
module rcv_shift #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sin,
  input  logic                     rd_ready,
  input  logic                     clr_ovr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     byte_done,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  shreg, shreg_nxt;
  logic [CW-1:0]     bitc, bitc_nxt;
  logic [WIDTH-1:0]  word_in;
  logic              word_done;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic              full, pop, push_ok, drop;

  assign word_in   = {shreg[WIDTH-2:0], sin};
  assign word_done = start && (bitc == LAST_BIT);

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = IDLE;
    shreg_nxt = '0;
    bitc_nxt  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          shreg_nxt = word_in;
          bitc_nxt  = word_done ? '0 : CW'(1);
        end
      end
      SHIFT: begin
        if (start) begin
          state_nxt = SHIFT;
          shreg_nxt = word_in;
          bitc_nxt  = word_done ? '0 : bitc + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bitc      <= '0;
      byte_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bitc      <= bitc_nxt;
      byte_done <= word_done;
    end
  end

  // A full FIFO still accepts a word when the head is popped on the same edge.
  assign full     = (level == FULL_LVL);
  assign pop      = rd_valid && rd_ready;
  assign push_ok  = word_done && (!full || pop);
  assign drop     = word_done && full && !pop;
  assign rd_valid = (level != '0);
  assign rd_data  = mem[rptr];

  // NOTE: the storage is reset because rd_data must read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wptr] <= word_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

endmodule
